// File: rtl/psg_pkg.sv
// psg_pkg: shared constants for the SN76489-style PSG core.
// Contents: command-byte field positions, the attenuation-to-amplitude table,
// the noise rate constants and the latched-register descriptor type.
package psg_pkg;

    localparam int CMD_LATCH    = 7;
    localparam int CMD_CHAN_LSB = 5;
    localparam int CMD_TYPE     = 4;

    localparam logic [1:0] CHAN_NOISE = 2'd3;

    localparam logic [6:0] NOISE_RATE_0 = 7'd16;
    localparam logic [6:0] NOISE_RATE_1 = 7'd32;
    localparam logic [6:0] NOISE_RATE_2 = 7'd64;

    // 2 dB per step; 15 is silence.
    localparam logic [7:0] ATTN_LUT [16] = '{
        8'd255, 8'd203, 8'd161, 8'd128, 8'd102, 8'd81, 8'd64, 8'd51,
        8'd40,  8'd32,  8'd25,  8'd20,  8'd16,  8'd13, 8'd10, 8'd0
    };

    typedef struct packed {
        logic [1:0] chan;
        logic       is_attn;
    } latch_t;

    function automatic logic [6:0] noise_rate(input logic [1:0] r);
        return r == 2'd0 ? NOISE_RATE_0 : r == 2'd1 ? NOISE_RATE_1 : NOISE_RATE_2;
    endfunction

endpackage

// File: rtl/psg_tone_channel.sv
// psg_tone_channel: one square-wave tone generator driven by the PSG tick.
// Ports: clk, reset (sync, active-high), tick (PSG tick strobe),
//        period (half-period in ticks, 0 means 2^TONE_BITS),
//        state (square output), toggle (combinational strobe on the tick where state flips).
module psg_tone_channel #(
    parameter int TONE_BITS = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic [TONE_BITS-1:0] period,
    output logic                 state,
    output logic                 toggle
);

    logic [TONE_BITS:0] cnt;

    assign toggle = tick && cnt <= (TONE_BITS+1)'(1);

    // The period is sampled only at reload, so period writes never restart the counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            state <= 1'b0;
        end else if (toggle) begin
            cnt   <= period == '0 ? {1'b1, {TONE_BITS{1'b0}}} : {1'b0, period};
            state <= ~state;
        end else if (tick) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/sn_psg_core.sv
// sn_psg_core: SN76489-style PSG with three tone channels, one noise channel and a mixer.
// Ports: clk, reset (sync, active-high), wr_en/wr_data (command byte write, one per cycle),
//        chan_amp (registered per-channel amplitude, tone0 in LSBs, noise in MSBs),
//        audio_out (registered unsigned sum of the four channel amplitudes).
module sn_psg_core
    import psg_pkg::*;
#(
    parameter int                   CLK_DIV   = 16,
    parameter int                   TONE_BITS = 10,
    parameter int                   LFSR_BITS = 15,
    parameter logic [LFSR_BITS-1:0] LFSR_TAPS = 15'h0003,
    parameter int                   AMP_BITS  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic [4*AMP_BITS-1:0] chan_amp,
    output logic [AMP_BITS+1:0]   audio_out
);

    localparam int PW = CLK_DIV > 2 ? $clog2(CLK_DIV) : 1;
    localparam logic [LFSR_BITS-1:0] LFSR_SEED = {1'b1, {(LFSR_BITS-1){1'b0}}};

    logic [PW-1:0]        presc;
    logic                 tick;
    logic [3:0]           attn [4];
    logic [TONE_BITS-1:0] tone [3];
    logic [2:0]           noise_ctl;
    latch_t               lreg, tgt;
    logic                 is_latch, noise_wr;
    logic [2:0]           tone_state, tone_tog;
    logic                 unused_tog;
    logic [6:0]           ncnt;
    logic                 nstate, n_tog, fb;
    logic [LFSR_BITS-1:0] lfsr;
    logic [AMP_BITS-1:0]  amp_n [4];

    assign tick = presc == PW'(CLK_DIV - 1);

    always_ff @(posedge clk) begin
        if (reset) presc <= '0;
        else presc <= tick ? '0 : presc + 1'b1;
    end

    // Data bytes reuse the latched target; latch bytes both select and write.
    assign is_latch = wr_data[CMD_LATCH];
    assign tgt      = is_latch ? latch_t'({wr_data[CMD_CHAN_LSB +: 2], wr_data[CMD_TYPE]}) : lreg;
    assign noise_wr = wr_en && tgt.chan == CHAN_NOISE && !tgt.is_attn;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) attn[i] <= 4'hF;
            for (int i = 0; i < 3; i++) tone[i] <= '0;
            noise_ctl <= '0;
            lreg      <= '0;
        end else if (wr_en) begin
            lreg <= tgt;
            if (tgt.is_attn) attn[tgt.chan] <= wr_data[3:0];
            else if (tgt.chan == CHAN_NOISE) noise_ctl <= wr_data[2:0];
            else if (is_latch) tone[tgt.chan][3:0] <= wr_data[3:0];
            else tone[tgt.chan][TONE_BITS-1:4] <= (TONE_BITS-4)'(wr_data[5:0]);
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_tone
        psg_tone_channel #(.TONE_BITS(TONE_BITS)) u_tone (
            .clk    (clk),
            .reset  (reset),
            .tick   (tick),
            .period (tone[g]),
            .state  (tone_state[g]),
            .toggle (tone_tog[g])
        );
    end

    assign unused_tog = ^tone_tog[1:0];

    // Rate 3 slaves the noise clock to tone2; the LFSR advances on noise-state rising edges.
    assign n_tog = noise_ctl[1:0] == 2'b11 ? tone_tog[2] : tick && ncnt <= 7'd1;
    assign fb    = noise_ctl[2] ? ^(lfsr & LFSR_TAPS) : lfsr[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            ncnt   <= '0;
            nstate <= 1'b0;
            lfsr   <= LFSR_SEED;
        end else begin
            if (n_tog) nstate <= ~nstate;
            if (tick && noise_ctl[1:0] != 2'b11) ncnt <= ncnt <= 7'd1 ? noise_rate(noise_ctl[1:0]) : ncnt - 1'b1;
            lfsr <= noise_wr ? LFSR_SEED : n_tog && !nstate ? {fb, lfsr[LFSR_BITS-1:1]} : lfsr;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) amp_n[i] = tone_state[i] ? AMP_BITS'(ATTN_LUT[attn[i]]) : '0;
        amp_n[3] = lfsr[0] ? AMP_BITS'(ATTN_LUT[attn[3]]) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chan_amp  <= '0;
            audio_out <= '0;
        end else begin
            for (int i = 0; i < 4; i++) chan_amp[i*AMP_BITS +: AMP_BITS] <= amp_n[i];
            audio_out <= (AMP_BITS+2)'(chan_amp[0 +: AMP_BITS]) + (AMP_BITS+2)'(chan_amp[AMP_BITS +: AMP_BITS])
                       + (AMP_BITS+2)'(chan_amp[2*AMP_BITS +: AMP_BITS]) + (AMP_BITS+2)'(chan_amp[3*AMP_BITS +: AMP_BITS]);
        end
    end

endmodule

// File: tb/tb_sn_psg_core.sv
// tb_sn_psg_core: directed, table-driven self-checking bench for sn_psg_core (default parameters).
module tb_sn_psg_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic [31:0] chan_amp;
    logic [9:0]  audio_out;

    sn_psg_core dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .chan_amp  (chan_amp),
        .audio_out (audio_out)
    );

    always #5 clk = ~clk;

    // Posedges since reset release; tick k lands on the edge where cyc becomes 16*k.
    int cyc = 0;
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          n;
        logic [31:0] bytes;
        logic [31:0] amp;
        int          aud;
    } vec_t;

    vec_t vt [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        wr_en = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wr(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic measure(input int ch, output int n);
        logic [7:0] v0;
        v0 = chan_amp[ch*8 +: 8];
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (chan_amp[ch*8 +: 8] == v0 && n < 20000);
    endtask

    initial begin
        int bad;
        int n;
        logic [14:0] m;

        vt[0] = '{1, 32'h00000090, 32'h000000FF, 255};
        vt[1] = '{3, 32'h00D6B492, 32'h004066A1, 327};
        vt[2] = '{1, 32'h0000009F, 32'h00000000, 0};
        vt[3] = '{2, 32'h000007B0, 32'h00003300, 51};
        vt[4] = '{3, 32'h00DAB998, 32'h00192028, 97};
        vt[5] = '{4, 32'hFEDDBC9B, 32'h000D1014, 49};
        vt[6] = '{2, 32'h0000B593, 32'h00005180, 209};
        vt[7] = '{2, 32'h00009F91, 32'h00000000, 0};
        vt[8] = '{3, 32'h003F8090, 32'h000000FF, 255};

        do_reset();
        check("reset_chan_amp", chan_amp, 0);
        check("reset_audio", audio_out, 0);

        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (chan_amp !== 32'h0 || audio_out !== 10'h0) bad++;
        end
        check("idle_1000_silent", bad, 0);

        @(negedge clk);
        reset   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h90;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wr_en = 1'b0;
        wait_cyc(100);
        check("wr_ignored_in_reset", chan_amp, 0);

        for (int v = 0; v < 9; v++) begin
            do_reset();
            for (int i = 0; i < vt[v].n; i++) wr(vt[v].bytes[i*8 +: 8]);
            wait_cyc(100);
            check($sformatf("vec%0d_chan_amp", v), chan_amp, vt[v].amp);
            check($sformatf("vec%0d_audio", v), audio_out, vt[v].aud);
        end

        do_reset();
        wr(8'h8E);
        wr(8'h0F);
        wr(8'h90);
        measure(0, n);
        measure(0, n);
        check("tone0_254_half1", n, 4064);
        check("tone0_254_low", chan_amp[7:0], 0);
        measure(0, n);
        check("tone0_254_half2", n, 4064);
        check("tone0_254_high", chan_amp[7:0], 255);

        do_reset();
        wr(8'h81);
        wr(8'h90);
        measure(0, n);
        measure(0, n);
        check("tone0_p1_a", n, 16);
        measure(0, n);
        check("tone0_p1_b", n, 16);
        wr(8'h00);
        measure(0, n);
        measure(0, n);
        check("tone0_p1_after_data", n, 16);
        measure(0, n);
        check("tone0_p1_after_data2", n, 16);

        do_reset();
        wr(8'hE4);
        wr(8'hF0);
        m = 15'h4000;
        for (int s = 1; s <= 24; s++) begin
            wait_cyc(16 * (1 + 32 * (s - 1)) + 258);
            m = {m[0] ^ m[1], m[14:1]};
            check($sformatf("white_shift%0d", s), chan_amp[31:24], m[0] ? 255 : 0);
        end

        do_reset();
        wr(8'hC5);
        wr(8'hE3);
        wr(8'hD0);
        wr(8'hF0);
        measure(2, n);
        measure(2, n);
        check("tone2_p5_a", n, 80);
        measure(2, n);
        check("tone2_p5_b", n, 80);
        wait_cyc(1900);
        check("noise_t2_before14", chan_amp[31:24], 0);
        wait_cyc(2150);
        check("noise_t2_after14", chan_amp[31:24], 255);
        wait_cyc(2300);
        check("noise_t2_after15", chan_amp[31:24], 0);

        do_reset();
        wr(8'h90);
        wr(8'hB0);
        wr(8'hD0);
        wr(8'hF0);
        wait_cyc(6900);
        check("mix_all_chan_amp", chan_amp, 32'hFFFFFFFF);
        check("mix_all_audio", audio_out, 1020);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_reset_audio", audio_out, 0);
        check("mid_reset_chan_amp", chan_amp, 0);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sn_psg_core.md
SN_PSG_CORE -- requirements
Module: sn_psg_core

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16, meaning system clocks per PSG tick (≥2).
REQ-002 SHALL have parameter TONE_BITS, default 10, meaning tone period register width.
REQ-003 SHALL have parameter LFSR_BITS, default 15, meaning noise shift-register length.
REQ-004 SHALL have parameter LFSR_TAPS, default 15'h0003, meaning white-noise feedback mask (XOR of masked bits).
REQ-005 SHALL have parameter AMP_BITS, default 8, meaning per-channel amplitude width.
REQ-006 SHALL have port clk, input, 1, clock.
REQ-007 SHALL have port reset, input, 1, reset: synchronous, active-high.
REQ-008 SHALL have port wr_en, input, 1, write strobe; one byte accepted per asserted cycle, no backpressure.
REQ-009 SHALL have port wr_data, input, 8, SN76489-format command byte.
REQ-010 SHALL have port chan_amp, output, 4*AMP_BITS, per-channel amplitude; tone0 in LSBs, noise in MSBs.
REQ-011 SHALL have port audio_out, output, AMP_BITS+2, registered mix of all four channels.

Function
REQ-012 SHALL decode a latch byte (bit7=1) as: bits6:5 channel (3=noise), bit4 type (1=attenuation, 0=tone/noise), bits3:0 data; and SHALL record channel/type as the latched register.
REQ-013 SHALL write latch-byte data to attenuation[3:0], tone period[3:0], or noise control[2:0] per the decoded target.
REQ-014 SHALL, on a data byte (bit7=0), write bits5:0 to tone period[TONE_BITS-1:4] when the latched register is a tone period, else write bits3:0 to the latched register's low field.
REQ-015 SHALL update registers at the clk edge where wr_en=1; the new value is visible from the next cycle.
REQ-016 SHALL generate a one-cycle tick every CLK_DIV clk cycles from a free-running prescaler.
REQ-017 SHALL, per tone channel on each tick: if counter ≤1, reload counter with period (period 0 reloads 2^TONE_BITS) and toggle the square state; else decrement.
REQ-018 SHALL therefore give a half-period of N ticks for N≥1 and 2^TONE_BITS ticks for N=0.
REQ-019 SHALL NOT reset tone counters on period writes; a new period takes effect at the next reload.
REQ-020 SHALL select the noise reload from noise bits1:0: 00→16, 01→32, 10→64 ticks; 11→clock noise on each tone2 toggle.
REQ-021 SHALL shift the LFSR right once per rising (0→1) transition of the noise state. The shifted-in MSB SHALL be the XOR of (lfsr & LFSR_TAPS) when noise bit2=1 (white), else lfsr[0] (periodic).
REQ-022 SHALL reload the LFSR to 1<<(LFSR_BITS-1) on any write to the noise control register. This has priority over a same-cycle shift.
REQ-023 SHALL drive channel amplitude as ATTN_LUT[attenuation] when the tone state is 1 (noise: lfsr[0]=1), else 0.
REQ-024 SHALL use ATTN_LUT (2 dB/step, AMP_BITS=8) = 255,203,161,128,102,81,64,51,40,32,25,20,16,13,10,0.
REQ-025 SHALL register chan_amp one cycle after state change, and audio_out as the unsigned sum of chan_amp one further cycle later.
REQ-026 SHALL produce no overflow, because the sum width is AMP_BITS+2.

Reset
REQ-027 SHALL, while reset=1, set all attenuations to 4'hF, tone periods to 0, and noise control to 0.
REQ-028 SHALL, while reset=1, set the latched register to tone0 period, zero the counters, prescaler and square states, and set the LFSR to 1<<(LFSR_BITS-1).
REQ-029 SHALL drive chan_amp=0 and audio_out=0 on the cycle after reset.
REQ-030 SHALL ignore wr_en while reset=1.
REQ-031 SHALL fully reinitialise on reset asserted mid-operation, with no residual state.

Structure
REQ-032 SHALL place ATTN_LUT, noise rate constants (16/32/64), and command-field positions in shared package psg_pkg.
REQ-033 SHALL implement each tone channel as sub-module psg_tone_channel (counter, square state, toggle-event output), instantiated three times.
REQ-034 SHALL implement noise, register file, prescaler and mixer in sn_psg_core.

Verification
REQ-035 SHALL cover: reset, then no writes for 1000 cycles -> chan_amp=0 and audio_out=0 throughout.
REQ-036 SHALL cover: write 0x8E, 0x0F (tone0 period 0x0FE), then 0x90 (attn0=0) -> tone0 toggles every 254 ticks (4064 clk), amplitude 255/0.
REQ-037 SHALL cover: write 0x81 with no data byte (period 1) -> tone0 toggles every tick; write 0x00 -> period 0x001 unchanged, toggling continues.
REQ-038 SHALL cover: write 0xE4 (white, rate 16) and 0xF0 -> LFSR shifts every 32 ticks; the first 15 lfsr[0] values match a reference model with taps 0x0003.
REQ-039 SHALL cover: write 0xE3 with tone2 period 5 -> the noise state toggles on every tone2 toggle (every 5 ticks), and the LFSR shifts every 10 ticks.
REQ-040 SHALL cover: all four channels at attn 0 with states high -> audio_out=1020; assert reset mid-tone -> audio_out=0 two cycles later.
